// File: rtl/prog_run_controller.sv
// Run controller: accepts a 4-phase host run request, loads program addresses,
// starts the core program counter and reports completion status and run length.
module prog_run_controller #(
    parameter int unsigned PC_BITS  = 9,
    parameter int unsigned P0_START = 0,
    parameter int unsigned P0_DONE  = 435,
    parameter int unsigned P1_START = 436,
    parameter int unsigned P1_DONE  = 300,
    parameter int unsigned P2_START = 301,
    parameter int unsigned P2_DONE  = 511,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               host_req,
    input  logic [1:0]         host_prog,
    input  logic               host_abort,
    output logic               host_ack,
    output logic [1:0]         host_err,
    output logic               busy,
    output logic               core_start,
    input  logic               core_done,
    output logic [PC_BITS-1:0] core_start_addr,
    output logic [PC_BITS-1:0] core_done_addr,
    output logic               dm_host_sel,
    output logic [15:0]        cycle_count
);

    localparam int unsigned CNT_BITS   = 16;
    localparam logic [CNT_BITS-1:0] LAST_CYCLE = CNT_BITS'(TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] COUNT_MAX  = {CNT_BITS{1'b1}};

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BAD     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t state, state_next;

    logic               ack_next;
    logic [1:0]         err_next;
    logic               busy_next;
    logic               start_next;
    logic               sel_next;
    logic [CNT_BITS-1:0] count_next;
    logic [PC_BITS-1:0] saddr_next;
    logic [PC_BITS-1:0] daddr_next;
    logic [PC_BITS-1:0] prog_start;
    logic [PC_BITS-1:0] prog_done;
    logic               exit_run;
    logic [1:0]         exit_err;

    // Program address table, indexed by the requested program.
    always_comb begin
        prog_start = PC_BITS'(P0_START);
        prog_done  = PC_BITS'(P0_DONE);
        case (host_prog)
            2'd1: begin
                prog_start = PC_BITS'(P1_START);
                prog_done  = PC_BITS'(P1_DONE);
            end
            2'd2: begin
                prog_start = PC_BITS'(P2_START);
                prog_done  = PC_BITS'(P2_DONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            host_ack        <= 1'b0;
            host_err        <= ERR_OK;
            busy            <= 1'b0;
            core_start      <= 1'b0;
            dm_host_sel     <= 1'b1;
            cycle_count     <= '0;
            core_start_addr <= PC_BITS'(P0_START);
            core_done_addr  <= PC_BITS'(P0_DONE);
        end else begin
            state           <= state_next;
            host_ack        <= ack_next;
            host_err        <= err_next;
            busy            <= busy_next;
            core_start      <= start_next;
            dm_host_sel     <= sel_next;
            cycle_count     <= count_next;
            core_start_addr <= saddr_next;
            core_done_addr  <= daddr_next;
        end
    end

    // Outputs are computed for the state being entered so they are valid in it.
    always_comb begin
        state_next = state;
        ack_next   = host_ack;
        err_next   = host_err;
        busy_next  = busy;
        start_next = 1'b0;
        sel_next   = dm_host_sel;
        count_next = cycle_count;
        saddr_next = core_start_addr;
        daddr_next = core_done_addr;
        exit_run   = 1'b0;
        exit_err   = ERR_OK;

        case (state)
            IDLE: begin
                if (host_req) begin
                    if (host_prog == 2'd3) begin
                        state_next = FINISH;
                        ack_next   = 1'b1;
                        err_next   = ERR_BAD;
                    end else begin
                        state_next = LOAD;
                        busy_next  = 1'b1;
                        sel_next   = 1'b0;
                        err_next   = ERR_OK;
                        count_next = '0;
                        saddr_next = prog_start;
                        daddr_next = prog_done;
                    end
                end
            end
            LOAD: begin
                state_next = START;
                start_next = 1'b1;
            end
            START: begin
                state_next = RUN;
            end
            RUN: begin
                // The exiting cycle is still counted.
                if (cycle_count != COUNT_MAX) begin
                    count_next = cycle_count + CNT_BITS'(1);
                end
                if (core_done) begin
                    exit_run = 1'b1;
                    exit_err = ERR_OK;
                end else if (host_abort) begin
                    exit_run = 1'b1;
                    exit_err = ERR_ABORT;
                end else if (cycle_count == LAST_CYCLE) begin
                    exit_run = 1'b1;
                    exit_err = ERR_TIMEOUT;
                end
                if (exit_run) begin
                    state_next = FINISH;
                    ack_next   = 1'b1;
                    err_next   = exit_err;
                    busy_next  = 1'b0;
                    sel_next   = 1'b1;
                end
            end
            FINISH: begin
                if (!host_req) begin
                    state_next = IDLE;
                    ack_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_run_controller.sv
// Directed bench for prog_run_controller: one default instance and one with TIMEOUT=8.
module tb_prog_run_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       host_req;
    logic       req_t;
    logic [1:0] host_prog;
    logic       host_abort;
    logic       core_done;

    logic       host_ack, busy, core_start, dm_host_sel;
    logic [1:0] host_err;
    logic [8:0] core_start_addr, core_done_addr;
    logic [15:0] cycle_count;

    logic       ack_t, busy_t, start_t, sel_t;
    logic [1:0] err_t;
    logic [8:0] saddr_t, daddr_t;
    logic [15:0] count_t;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    prog_run_controller dut (
        .clock(clock), .reset_n(reset_n), .host_req(host_req), .host_prog(host_prog),
        .host_abort(host_abort), .host_ack(host_ack), .host_err(host_err), .busy(busy),
        .core_start(core_start), .core_done(core_done), .core_start_addr(core_start_addr),
        .core_done_addr(core_done_addr), .dm_host_sel(dm_host_sel), .cycle_count(cycle_count)
    );

    prog_run_controller #(.TIMEOUT(8)) dut_t (
        .clock(clock), .reset_n(reset_n), .host_req(req_t), .host_prog(host_prog),
        .host_abort(host_abort), .host_ack(ack_t), .host_err(err_t), .busy(busy_t),
        .core_start(start_t), .core_done(core_done), .core_start_addr(saddr_t),
        .core_done_addr(daddr_t), .dm_host_sel(sel_t), .cycle_count(count_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},   32'(host_ack), 32'd0);
        check({tag, "_err"},   32'(host_err), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_start"}, 32'(core_start), 32'd0);
        check({tag, "_sel"},   32'(dm_host_sel), 32'd1);
        check({tag, "_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_saddr"}, 32'(core_start_addr), 32'd0);
        check({tag, "_daddr"}, 32'(core_done_addr), 32'd435);
    endtask

    initial begin
        reset_n    = 1'b0;
        host_req   = 1'b0;
        req_t      = 1'b0;
        host_prog  = 2'd0;
        host_abort = 1'b0;
        core_done  = 1'b0;
        #12;
        check_reset_values("rst");
        #5 reset_n = 1'b1;
        step(1);

        // Program 1, done at the 20th RUN edge; prog changes after sampling ignored.
        host_prog = 2'd1;
        host_req  = 1'b1;
        step(1);
        check("p1_load_busy", 32'(busy), 32'd1);
        check("p1_load_sel", 32'(dm_host_sel), 32'd0);
        check("p1_load_start", 32'(core_start), 32'd0);
        check("p1_saddr", 32'(core_start_addr), 32'd436);
        check("p1_daddr", 32'(core_done_addr), 32'd300);
        host_prog = 2'd2;
        step(1);
        check("p1_start_pulse", 32'(core_start), 32'd1);
        check("p1_saddr_hold", 32'(core_start_addr), 32'd436);
        step(1);
        check("p1_start_end", 32'(core_start), 32'd0);
        check("p1_run_busy", 32'(busy), 32'd1);
        step(19);
        check("p1_no_ack_yet", 32'(host_ack), 32'd0);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        check("p1_ack", 32'(host_ack), 32'd1);
        check("p1_err", 32'(host_err), 32'd0);
        check("p1_count", 32'(cycle_count), 32'd20);
        check("p1_busy", 32'(busy), 32'd0);
        check("p1_sel", 32'(dm_host_sel), 32'd1);
        step(1);
        check("p1_ack_held", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        step(1);
        check("p1_ack_drop", 32'(host_ack), 32'd0);
        check("p1_count_idle", 32'(cycle_count), 32'd20);

        // Invalid program 3.
        host_prog = 2'd3;
        host_req  = 1'b1;
        step(1);
        check("bad_ack", 32'(host_ack), 32'd1);
        check("bad_err", 32'(host_err), 32'd1);
        check("bad_sel", 32'(dm_host_sel), 32'd1);
        check("bad_start", 32'(core_start), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        host_req = 1'b0;
        step(1);
        check("bad_ack_drop", 32'(host_ack), 32'd0);
        check("bad_err_hold", 32'(host_err), 32'd1);

        // Timeout on the TIMEOUT=8 instance.
        host_prog = 2'd0;
        req_t     = 1'b1;
        step(3);
        step(7);
        check("to_not_yet", 32'(ack_t), 32'd0);
        step(1);
        check("to_ack", 32'(ack_t), 32'd1);
        check("to_err", 32'(err_t), 32'd2);
        check("to_count", 32'(count_t), 32'd8);
        check("to_main_idle", 32'(busy), 32'd0);
        req_t = 1'b0;
        step(1);
        check("to_ack_drop", 32'(ack_t), 32'd0);

        // Done and abort together at the 5th RUN edge; req dropped mid-run.
        host_prog = 2'd2;
        host_req  = 1'b1;
        step(1);
        check("p2_saddr", 32'(core_start_addr), 32'd301);
        check("p2_daddr", 32'(core_done_addr), 32'd511);
        step(2);
        host_req = 1'b0;
        step(4);
        check("p2_still_run", 32'(busy), 32'd1);
        host_abort = 1'b1;
        core_done  = 1'b1;
        step(1);
        host_abort = 1'b0;
        core_done  = 1'b0;
        check("both_ack", 32'(host_ack), 32'd1);
        check("both_err", 32'(host_err), 32'd0);
        check("both_count", 32'(cycle_count), 32'd5);
        step(1);
        check("both_ack_drop", 32'(host_ack), 32'd0);

        // Abort held through LOAD/START is ignored; abort alone at 5th RUN edge.
        host_prog  = 2'd0;
        host_req   = 1'b1;
        host_abort = 1'b1;
        step(2);
        check("ab_start_pulse", 32'(core_start), 32'd1);
        step(1);
        host_abort = 1'b0;
        check("ab_run", 32'(busy), 32'd1);
        check("ab_no_ack", 32'(host_ack), 32'd0);
        step(4);
        host_abort = 1'b1;
        step(1);
        host_abort = 1'b0;
        check("ab_err", 32'(host_err), 32'd3);
        check("ab_count", 32'(cycle_count), 32'd5);
        check("ab_ack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        step(1);

        // core_done held through START: ignored there, exits at first RUN edge.
        core_done = 1'b1;
        host_req  = 1'b1;
        step(2);
        check("dn_start_pulse", 32'(core_start), 32'd1);
        step(1);
        check("dn_ignored_start", 32'(host_ack), 32'd0);
        check("dn_run_busy", 32'(busy), 32'd1);
        step(1);
        check("dn_ack", 32'(host_ack), 32'd1);
        check("dn_count", 32'(cycle_count), 32'd1);
        core_done = 1'b0;
        host_req  = 1'b0;
        step(1);

        // Asynchronous reset mid-RUN, then req already high restarts at first edge.
        host_prog = 2'd1;
        host_req  = 1'b1;
        step(6);
        check("rr_running", 32'(busy), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check_reset_values("rr");
        #2 reset_n = 1'b1;
        step(1);
        check("rr_relaunch_busy", 32'(busy), 32'd1);
        check("rr_relaunch_saddr", 32'(core_start_addr), 32'd436);
        step(2);
        core_done = 1'b1;
        step(1);
        core_done = 1'b0;
        check("rr_ack", 32'(host_ack), 32'd1);
        check("rr_count", 32'(cycle_count), 32'd1);
        host_req = 1'b0;
        step(1);
        check("rr_ack_drop", 32'(host_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
